// File: rtl/spi_frame_receiver.sv
// rtl/spi_frame_receiver.sv - SPI slave frame receiver with synchronizers, framing FSM and show-ahead FIFO
module spi_frame_receiver #(
    parameter int DATA_W      = 9,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sclk,
    input  logic                          cs,
    input  logic                          mosi,
    output logic [DATA_W-1:0]             rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          frame_error,
    input  logic                          clear_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, WAIT_CS_HIGH} state_t;

    state_t                 r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
    logic [SYNC_STAGES:0]   r_arm;
    logic                   r_sclk_prev, r_cs_prev;
    logic                   w_sclk_s, w_cs_s, w_mosi_s, w_rise, w_cs_fall;
    logic                   w_start, w_shift, w_last, w_ferr_set;
    logic [CW-1:0]          r_bit_cnt;
    logic [DATA_W-1:0]      r_shift;
    logic                   r_push;
    logic [DATA_W-1:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
    logic [AW:0]            r_count;
    logic                   w_pop, w_full, w_wr, w_ovf_set;

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
    assign w_rise   = w_sclk_s & ~r_sclk_prev;
    // r_arm masks the reset value of the cs synchronizer so only a genuine post-reset falling edge starts a frame
    assign w_cs_fall = r_arm[SYNC_STAGES] & r_cs_prev & ~w_cs_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b1;
            r_arm       <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_prev <= w_sclk_s;
            r_cs_prev   <= w_cs_s;
            r_arm       <= {r_arm[SYNC_STAGES-1:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_shift     = 1'b0;
        w_last      = 1'b0;
        w_ferr_set  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt = SHIFT;
                    w_start     = 1'b1;
                end
            end
            SHIFT: begin
                if (w_cs_s) begin
                    w_state_nxt = IDLE;
                    w_ferr_set  = 1'b1;
                end else if (w_rise) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == CW'(DATA_W - 1)) begin
                        w_last      = 1'b1;
                        w_state_nxt = WAIT_CS_HIGH;
                    end
                end
            end
            WAIT_CS_HIGH: begin
                if (w_cs_s)      w_state_nxt = IDLE;
                else if (w_rise) w_ferr_set  = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_push    <= 1'b0;
        end else begin
            r_push <= w_last;
            if (w_start) begin
                r_bit_cnt <= '0;
                r_shift   <= '0;
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + CW'(1);
                r_shift   <= {r_shift[DATA_W-2:0], w_mosi_s};
            end
        end
    end

    assign w_pop      = rx_valid & rx_ready;
    assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_wr       = r_push & (~w_full | w_pop);
    assign w_ovf_set  = r_push & w_full & ~w_pop;
    assign fifo_count = r_count;
    assign rx_valid   = (r_count != '0);
    assign rx_data    = rx_valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= r_shift;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A set event in the same cycle wins over clear_err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            if (w_ovf_set)      overflow <= 1'b1;
            else if (clear_err) overflow <= 1'b0;
            if (w_ferr_set)     frame_error <= 1'b1;
            else if (clear_err) frame_error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_frame_receiver.sv
// tb/tb_spi_frame_receiver.sv - directed self-checking bench for spi_frame_receiver
module tb_spi_frame_receiver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk, cs, mosi;
    logic [8:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [3:0] fifo_count;
    logic       overflow, frame_error;
    logic       clear_err;

    int n_checks = 0;
    int n_errors = 0;
    int lat;

    spi_frame_receiver #(.DATA_W(9), .FIFO_DEPTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .fifo_count(fifo_count), .overflow(overflow), .frame_error(frame_error),
        .clear_err(clear_err)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // sclk half period of 6 clk cycles, all SPI pins change on clk falling edges
    task automatic half_wait();
        repeat (6) @(negedge clk);
    endtask

    task automatic send_bits(input logic [15:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = val[i];
            half_wait();
            sclk = 1'b1;
            half_wait();
            sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [8:0] val);
        cs = 1'b0;
        half_wait();
        send_bits({7'd0, val}, 9);
        half_wait();
        cs = 1'b1;
        half_wait();
        half_wait();
    endtask

    task automatic pop_check(input string tag, input logic [8:0] exp);
        @(negedge clk);
        check(tag, rx_data, exp);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
        rx_ready = 1'b0; clear_err = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("reset rx_valid", rx_valid, 0);
        check("reset rx_data", rx_data, 0);
        check("reset fifo_count", fifo_count, 0);
        check("reset overflow", overflow, 0);
        check("reset frame_error", frame_error, 0);

        // single frame 0x1A5 with latency measured from the 9th sclk rise
        cs = 1'b0;
        half_wait();
        send_bits(16'h00D2, 8);
        mosi = 1'b1;
        half_wait();
        sclk = 1'b1;
        lat = 0;
        while (!rx_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check("single latency within 5", (lat <= 5), 1);
        if (lat < 6) repeat (6 - lat) @(negedge clk);
        sclk = 1'b0;
        half_wait();
        cs = 1'b1;
        half_wait();
        check("single rx_valid", rx_valid, 1);
        check("single fifo_count", fifo_count, 1);
        check("single frame_error", frame_error, 0);
        pop_check("single rx_data", 9'h1A5);
        check("single drained", fifo_count, 0);

        // burst of 9 frames into depth-8 FIFO with no consumer
        for (int i = 0; i < 9; i++) send_frame(9'(i));
        @(negedge clk);
        check("burst fifo_count", fifo_count, 8);
        check("burst overflow", overflow, 1);
        check("burst head stable", rx_data, 0);
        for (int i = 0; i < 8; i++) pop_check($sformatf("burst pop %0d", i), 9'(i));
        check("burst drained", fifo_count, 0);
        check("burst rx_valid low", rx_valid, 0);
        pulse_clear();
        check("burst overflow cleared", overflow, 0);

        // truncated frame then a good frame
        cs = 1'b0;
        half_wait();
        send_bits(16'h0015, 5);
        half_wait();
        cs = 1'b1;
        half_wait();
        half_wait();
        send_frame(9'h0FF);
        check("trunc frame_error", frame_error, 1);
        check("trunc fifo_count", fifo_count, 1);
        pop_check("trunc rx_data", 9'h0FF);
        pulse_clear();
        check("trunc frame_error cleared", frame_error, 0);

        // 11 edges in one cs window carrying 0x155 followed by two extra bits
        cs = 1'b0;
        half_wait();
        send_bits(16'h0557, 11);
        half_wait();
        cs = 1'b1;
        half_wait();
        half_wait();
        check("extra fifo_count", fifo_count, 1);
        check("extra frame_error", frame_error, 1);
        check("extra overflow", overflow, 0);
        pulse_clear();
        check("extra frame_error cleared", frame_error, 0);
        pop_check("extra rx_data", 9'h155);
        check("extra drained", fifo_count, 0);

        // full FIFO with a pop landing in the same cycle as the new push
        for (int i = 0; i < 8; i++) send_frame(9'h010 + 9'(i));
        check("full fifo_count", fifo_count, 8);
        cs = 1'b0;
        half_wait();
        send_bits(16'h0055, 8);
        mosi = 1'b0;
        half_wait();
        sclk = 1'b1;
        repeat (3) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        repeat (2) @(negedge clk);
        sclk = 1'b0;
        half_wait();
        cs = 1'b1;
        half_wait();
        check("pushpop fifo_count", fifo_count, 8);
        check("pushpop overflow", overflow, 0);
        for (int i = 1; i < 8; i++) pop_check($sformatf("pushpop pop %0d", i), 9'h010 + 9'(i));
        pop_check("pushpop new word", 9'h0AA);
        check("pushpop drained", fifo_count, 0);

        // reset in the middle of a frame with a word stored and frame_error set
        send_frame(9'h07A);
        cs = 1'b0;
        half_wait();
        send_bits(16'h0005, 3);
        half_wait();
        cs = 1'b1;
        half_wait();
        half_wait();
        check("prereset fifo_count", fifo_count, 1);
        check("prereset frame_error", frame_error, 1);
        cs = 1'b0;
        half_wait();
        send_bits(16'h000B, 4);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset rx_valid", rx_valid, 0);
        check("midreset rx_data", rx_data, 0);
        check("midreset fifo_count", fifo_count, 0);
        check("midreset frame_error", frame_error, 0);
        check("midreset overflow", overflow, 0);
        rst_n = 1'b1;
        send_bits(16'h0015, 5);
        half_wait();
        check("postreset no capture", fifo_count, 0);
        check("postreset no error", frame_error, 0);
        cs = 1'b1;
        half_wait();
        half_wait();
        send_frame(9'h003);
        check("postreset fifo_count", fifo_count, 1);
        check("postreset frame_error", frame_error, 0);
        pop_check("postreset rx_data", 9'h003);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
